// File: rtl/rle_decoder_pkg.sv
// Shared constants and types for the RLE decoder: word field layout,
// FSM state encoding, default buffer depth and field-extraction helpers.
package rle_decoder_pkg;

    localparam int WORD_W             = 16;
    localparam int COUNT_MSB          = 15;
    localparam int COUNT_LSB          = 8;
    localparam int SYM_MSB            = 7;
    localparam int SYM_LSB            = 0;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    function automatic logic [7:0] word_count(input logic [WORD_W-1:0] w);
        return w[COUNT_MSB:COUNT_LSB];
    endfunction

    function automatic logic [7:0] word_symbol(input logic [WORD_W-1:0] w);
        return w[SYM_MSB:SYM_LSB];
    endfunction

endpackage

// File: rtl/rle_word_fifo.sv
// Word buffer between the UART receiver and the run expander.
// Show-ahead read: rdata always presents the head word; pop advances it.
// A push while full is accepted only if a pop happens on the same edge.
module rle_word_fifo
    import rle_decoder_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WORD_W-1:0]        wdata,
    input  logic                     pop,
    output logic [WORD_W-1:0]        rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign empty   = (level == '0);
    assign full    = (level == LW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Storage array; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/rle_decoder.sv
// Run-length decoder: buffers {count, symbol} words from the UART receiver
// and expands each into `count` copies of `symbol` on a valid/ready output.
module rle_decoder
    import rle_decoder_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          din_valid,
    input  logic [15:0]                   din,
    output logic                          dout_valid,
    output logic [7:0]                    dout,
    input  logic                          dout_ready,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    state_t            state;
    logic [7:0]        remaining;
    logic              head_ready;
    logic [WORD_W-1:0] head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              pop;
    logic              drop;

    rle_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (din_valid),
        .wdata (din),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    // head_ready lags fifo occupancy by one edge, so a word written into an
    // empty buffer is only consumed on the second edge after it was sampled;
    // words already waiting behind a run are taken on the first IDLE edge.
    assign pop  = (state == IDLE) && !fifo_empty && head_ready;
    assign drop = din_valid && fifo_full && !pop;
    assign busy = (state == EMIT) || !fifo_empty;

    // Decoder FSM with registered output byte, valid flag and overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            dout       <= '0;
            dout_valid <= 1'b0;
            remaining  <= '0;
            overflow   <= 1'b0;
            head_ready <= 1'b0;
        end else begin
            head_ready <= !fifo_empty;
            if (drop) begin
                overflow <= 1'b1;
            end
            case (state)
                IDLE: begin
                    dout_valid <= 1'b0;
                    // Zero-count words are popped and discarded silently.
                    if (pop && (word_count(head) != 8'd0)) begin
                        dout       <= word_symbol(head);
                        remaining  <= word_count(head);
                        dout_valid <= 1'b1;
                        state      <= EMIT;
                    end
                end
                EMIT: begin
                    if (dout_ready) begin
                        if (remaining == 8'd1) begin
                            remaining  <= '0;
                            dout_valid <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            remaining <= remaining - 8'd1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    dout_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rle_decoder.sv
// Directed self-checking bench for rle_decoder (FIFO_DEPTH = 4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_rle_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        din_valid;
    logic [15:0] din;
    logic        dout_valid;
    logic [7:0]  dout;
    logic        dout_ready;
    logic        busy;
    logic        overflow;
    logic [2:0]  level;

    int checks = 0;
    int passes = 0;

    rle_decoder #(
        .FIFO_DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (din_valid),
        .din        (din),
        .dout_valid (dout_valid),
        .dout       (dout),
        .dout_ready (dout_ready),
        .busy       (busy),
        .overflow   (overflow),
        .level      (level)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] w);
        din       = w;
        din_valid = 1'b1;
        step();
        din_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic wait_valid(input string name, input int budget);
        int k;
        k = 0;
        while (!dout_valid && k < budget) begin
            step();
            k++;
        end
        checks++;
        if (dout_valid !== 1'b1) $display("FAIL %s_timeout: dout_valid=%b expected 1 within %0d cycles", name, dout_valid, budget);
        else passes++;
    endtask

    task automatic test_reset();
        din_valid  = 1'b0;
        din        = '0;
        dout_ready = 1'b0;
        rst_n      = 1'b0;
        step();
        checks++; if (dout_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", dout_valid); else passes++;
        checks++; if (dout !== 8'h00) $display("FAIL reset_dout: got %h expected 00", dout); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passes++;
        checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b expected 0", overflow); else passes++;
        checks++; if (level !== 3'd0) $display("FAIL reset_level: got %0d expected 0", level); else passes++;
        rst_n = 1'b1;
        step();
        checks++; if (dout_valid !== 1'b0) $display("FAIL reset_release_valid: got %b expected 0", dout_valid); else passes++;
    endtask

    task automatic test_single_run();
        dout_ready = 1'b1;
        push_word(16'h0341);
        checks++; if (level !== 3'd1) $display("FAIL single_level: got %0d expected 1", level); else passes++;
        checks++; if (dout_valid !== 1'b0) $display("FAIL single_lat_e0: got %b expected 0", dout_valid); else passes++;
        step();
        checks++; if (dout_valid !== 1'b0) $display("FAIL single_lat_e1: got %b expected 0", dout_valid); else passes++;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (dout_valid !== 1'b1 || dout !== 8'h41) $display("FAIL single_byte%0d: valid=%b dout=%h expected 1/41", i, dout_valid, dout); else passes++;
        end
        step();
        checks++; if (dout_valid !== 1'b0) $display("FAIL single_end_valid: got %b expected 0", dout_valid); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL single_end_busy: got %b expected 0", busy); else passes++;
    endtask

    task automatic test_backpressure();
        dout_ready = 1'b0;
        push_word(16'h0242);
        step();
        step();
        checks++; if (dout_valid !== 1'b1 || dout !== 8'h42) $display("FAIL bp_first: valid=%b dout=%h expected 1/42", dout_valid, dout); else passes++;
        dout_ready = 1'b1;
        step();
        checks++; if (dout_valid !== 1'b1 || dout !== 8'h42) $display("FAIL bp_after_hs1: valid=%b dout=%h expected 1/42", dout_valid, dout); else passes++;
        dout_ready = 1'b0;
        step();
        checks++; if (dout_valid !== 1'b1 || dout !== 8'h42) $display("FAIL bp_stall1: valid=%b dout=%h expected 1/42", dout_valid, dout); else passes++;
        step();
        checks++; if (dout_valid !== 1'b1 || dout !== 8'h42) $display("FAIL bp_stall2: valid=%b dout=%h expected 1/42", dout_valid, dout); else passes++;
        dout_ready = 1'b1;
        step();
        checks++; if (dout_valid !== 1'b0) $display("FAIL bp_done: valid=%b expected 0", dout_valid); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL bp_busy: got %b expected 0", busy); else passes++;
    endtask

    task automatic test_zero_count();
        int n;
        int bad;
        dout_ready = 1'b1;
        push_word(16'h0055);
        push_word(16'h0166);
        n   = 0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (dout_valid) begin
                n++;
                if (dout !== 8'h66) bad++;
            end
            step();
        end
        checks++; if (n !== 1) $display("FAIL zero_bytes: got %0d bytes expected 1", n); else passes++;
        checks++; if (bad !== 0) $display("FAIL zero_symbol: got %0d bytes not 66 expected 0", bad); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [4:0] seen;
        logic [4:0] want;
        dout_ready = 1'b1;
        want = 5'b01011;
        push_word(16'h0231);
        push_word(16'h0132);
        step();
        for (int i = 0; i < 5; i++) begin
            seen[i] = dout_valid;
            step();
        end
        checks++; if (seen !== want) $display("FAIL b2b_valid_pattern: got %b expected %b", seen, want); else passes++;
    endtask

    task automatic test_overflow();
        logic [7:0] got [8];
        int n;
        dout_ready = 1'b0;
        push_word(16'h0101);
        wait_valid("ovf_first", 6);
        for (int i = 2; i <= 6; i++) begin
            push_word({8'h01, 8'(i)});
        end
        checks++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b expected 1", overflow); else passes++;
        checks++; if (level !== 3'd4) $display("FAIL ovf_level: got %0d expected 4", level); else passes++;
        checks++; if (dout_valid !== 1'b1 || dout !== 8'h01) $display("FAIL ovf_head: valid=%b dout=%h expected 1/01", dout_valid, dout); else passes++;
        dout_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (dout_valid) begin
                if (n < 8) got[n] = dout;
                n++;
            end
            step();
        end
        checks++; if (n !== 5) $display("FAIL ovf_count: got %0d bytes expected 5", n); else passes++;
        for (int k = 0; k < 5 && k < n; k++) begin
            checks++; if (got[k] !== 8'(k + 1)) $display("FAIL ovf_byte%0d: got %h expected %h", k, got[k], 8'(k + 1)); else passes++;
        end
        checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b expected 1", overflow); else passes++;
    endtask

    task automatic test_max_run();
        int n;
        int bad;
        do_reset();
        checks++; if (overflow !== 1'b0) $display("FAIL max_ovf_cleared: got %b expected 0", overflow); else passes++;
        dout_ready = 1'b1;
        push_word(16'hFF7A);
        n   = 0;
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            if (dout_valid) begin
                n++;
                if (dout !== 8'h7A) bad++;
            end
            step();
        end
        checks++; if (n !== 255) $display("FAIL max_count: got %0d bytes expected 255", n); else passes++;
        checks++; if (bad !== 0) $display("FAIL max_symbol: got %0d bytes not 7A expected 0", bad); else passes++;
        checks++; if (dout_valid !== 1'b0) $display("FAIL max_end_valid: got %b expected 0", dout_valid); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL max_end_busy: got %b expected 0", busy); else passes++;
    endtask

    task automatic test_reset_mid_run();
        int n;
        dout_ready = 1'b1;
        push_word(16'h1020);
        push_word(16'h0130);
        wait_valid("midrst_first", 6);
        n = 0;
        for (int i = 0; i < 20 && n < 5; i++) begin
            if (dout_valid) n++;
            step();
        end
        checks++; if (n !== 5) $display("FAIL midrst_pre_bytes: got %0d expected 5", n); else passes++;
        rst_n = 1'b0;
        #1;
        checks++; if (dout_valid !== 1'b0) $display("FAIL midrst_valid: got %b expected 0", dout_valid); else passes++;
        checks++; if (dout !== 8'h00) $display("FAIL midrst_dout: got %h expected 00", dout); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b expected 0", busy); else passes++;
        checks++; if (level !== 3'd0) $display("FAIL midrst_level: got %0d expected 0", level); else passes++;
        step();
        step();
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (dout_valid) n++;
        end
        checks++; if (n !== 0) $display("FAIL midrst_post_bytes: got %0d expected 0", n); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL midrst_post_busy: got %b expected 0", busy); else passes++;
    endtask

    initial begin
        test_reset();
        test_single_run();
        test_backpressure();
        test_zero_count();
        test_back_to_back();
        test_overflow();
        test_max_run();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/rle_decoder.md
RLE_DECODER -- requirements
Module: rle_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of 16-bit word slots in the input buffer (power of two, 2..16).
REQ-002 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port din_valid, input, 1 bit: one-cycle word strobe from the UART receiver (its done pulse).
REQ-005 SHALL have port din, input, 16 bits: RLE word; din[15:8] is the run count and din[7:0] is the symbol.
REQ-006 SHALL have port dout_valid, output, 1 bit: dout holds a valid decoded byte.
REQ-007 SHALL have port dout, output, 8 bits: decoded symbol byte.
REQ-008 SHALL have port dout_ready, input, 1 bit: consumer accepts the byte on any edge where dout_valid and dout_ready are both 1.
REQ-009 SHALL have port busy, output, 1 bit: the FSM is in EMIT or the FIFO is non-empty.
REQ-010 SHALL have port overflow, output, 1 bit: sticky flag, set when a word is dropped.
REQ-011 SHALL have port level, output, clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-012 SHALL write din into the FIFO on every edge where din_valid=1 and the FIFO is not full; the input is never back-pressured.
REQ-013 SHALL drop the word and set overflow=1 when din_valid=1 and the FIFO is full, unless a pop occurs on the same edge; push plus pop while full succeeds and level stays unchanged.
REQ-014 SHALL keep overflow at 1 until reset.
REQ-015 SHALL use an FSM with two states, IDLE and EMIT.
REQ-016 IDLE: with the FIFO non-empty, SHALL pop the head word and, if its count is nonzero, load the symbol and a remaining-count register and go to EMIT; a count of 0 SHALL be discarded with no output, staying in IDLE.
REQ-017 EMIT: SHALL hold dout_valid=1 with dout equal to the symbol; on each handshake edge, remaining SHALL decrement; the handshake with remaining=1 SHALL return to IDLE.
REQ-018 SHALL hold dout and dout_valid stable while dout_valid=1 and dout_ready=0.
REQ-019 SHALL emit exactly count bytes per word (1..255) in FIFO order; 8-bit count arithmetic SHALL never wrap.
REQ-020 Latency: with the FIFO empty and FSM in IDLE, dout_valid SHALL rise immediately after the 2nd rising edge following the edge that samples din_valid.
REQ-021 SHALL insert exactly one IDLE cycle, with dout_valid=0, between consecutive runs.
REQ-022 SHALL keep level equal to pushes minus pops, saturating at FIFO_DEPTH; FIFO pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-023 rst_n=0 SHALL asynchronously force: FSM to IDLE, FIFO empty, level=0, dout_valid=0, dout=8'h00, busy=0, overflow=0, remaining=0.
REQ-024 Reset during EMIT SHALL discard the partial run and all buffered words; no byte SHALL be emitted after reset release until a new word arrives.
REQ-025 SHALL release reset cleanly with no spurious dout_valid on the first edge after deassertion.

Structure
REQ-026 Constants SHALL live in a shared include/package: word field positions (COUNT_MSB=15, COUNT_LSB=8, SYM_MSB=7, SYM_LSB=0), state encodings, and default FIFO_DEPTH.
REQ-027 The FIFO SHALL be a separate sub-module, rle_word_fifo, with push/pop/full/empty/level, instantiated once; the FSM and output registers SHALL live in rle_decoder.

Verification
REQ-028 Single run: din=16'h0341 for 1 cycle, dout_ready=1 -> dout_valid high 3 consecutive cycles with dout=8'h41, first valid 2 edges after sampling, busy then 0.
REQ-029 Backpressure: din=16'h0242, dout_ready pattern 1,0,0,1 -> exactly 2 bytes of 8'h42, with dout and dout_valid unchanged during stalled cycles.
REQ-030 Zero count: din=16'h0055 then 16'h0166 -> only one byte 8'h66 emitted; 8'h55 never appears.
REQ-031 Overflow: dout_ready=0, push 16'h0101,16'h0102,16'h0103,16'h0104,16'h0105,16'h0106 (DEPTH=4, the first word already popped into EMIT) -> overflow=1, level=4, and with dout_ready=1 output is 01,02,03,04,05 only.
REQ-032 Max run: din=16'hFF7A, dout_ready=1 -> exactly 255 bytes of 8'h7A, then dout_valid=0.
REQ-033 Reset mid-run: din=16'h1020, assert rst_n=0 after 5 bytes -> all outputs at reset values immediately, no further bytes after release.
